// File: rtl/blitz_pkg.sv
// Shared types and default geometry for the blitz player/hook controller.
package blitz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_EXTEND    = 3'd3,
    ST_RETRACT   = 3'd4,
    ST_COOLDOWN  = 3'd5
  } blitz_hook_state_t;

  // Screen bounds and hook geometry of the stock playfield.
  localparam int unsigned SCREEN_Y_MIN        = 48;
  localparam int unsigned SCREEN_Y_MAX        = 138;
  localparam int unsigned PLAYER_Y_RESET      = 119;
  localparam int unsigned PLAYER_MOVE_STEP    = 2;
  localparam int unsigned HOOK_HOME_X         = 42;
  localparam int unsigned HOOK_MAX_X          = 94;
  localparam int unsigned HOOK_EXT_STEP       = 2;
  localparam int unsigned HOOK_RET_STEP       = 4;
  localparam int unsigned HOOK_Y_OFFSET       = 22;
  localparam int unsigned HOOK_COOLDOWN_DEF   = 30;

endpackage

// File: rtl/hook_cooldown_timer.sv
// Post-hook lockout counter: load, decrement once per frame, flag zero.
module hook_cooldown_timer #(
  parameter int unsigned FRAMES = 30,
  parameter int unsigned CW     = (FRAMES > 0) ? $clog2(FRAMES + 1) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic frame,
  output logic zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(FRAMES);
    end else if (frame && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/blitz_hook_ctrl.sv
// Player y / hook extend-retract controller. Optional post-hook lockout
// is built when BLITZ_HOOK_COOLDOWN_EN is defined.
module blitz_hook_ctrl
  import blitz_pkg::*;
#(
  parameter int unsigned X_W             = 9,
  parameter int unsigned Y_W             = 8,
  parameter int unsigned Y_RESET         = PLAYER_Y_RESET,
  parameter int unsigned Y_MIN           = SCREEN_Y_MIN,
  parameter int unsigned Y_MAX           = SCREEN_Y_MAX,
  parameter int unsigned MOVE_STEP       = PLAYER_MOVE_STEP,
  parameter int unsigned HOOK_X_HOME     = HOOK_HOME_X,
  parameter int unsigned HOOK_X_MAX      = HOOK_MAX_X,
  parameter int unsigned EXT_STEP        = HOOK_EXT_STEP,
  parameter int unsigned RET_STEP        = HOOK_RET_STEP,
  parameter int unsigned HOOK_Y_OFS      = HOOK_Y_OFFSET,
  parameter int unsigned COOLDOWN_FRAMES = HOOK_COOLDOWN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame,
  input  logic              go_up,
  input  logic              go_down,
  input  logic              grab,
  input  logic              grab_success,
  output logic [Y_W-1:0]    y,
  output logic [X_W-1:0]    hook_x,
  output logic [Y_W-1:0]    hook_y,
  output logic              hook_active,
  output logic              hook_caught,
  output logic              grab_done,
  output logic              busy,
  output blitz_hook_state_t dbg_state
);

  localparam logic [Y_W-1:0] Y_RST_V  = Y_W'(Y_RESET);
  localparam logic [Y_W-1:0] Y_MIN_V  = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0] Y_MAX_V  = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0] MOVE_V   = Y_W'(MOVE_STEP);
  localparam logic [Y_W-1:0] HY_OFS_V = Y_W'(HOOK_Y_OFS);
  localparam logic [X_W-1:0] HOME_V   = X_W'(HOOK_X_HOME);
  localparam logic [X_W-1:0] XMAX_V   = X_W'(HOOK_X_MAX);
  localparam logic [X_W-1:0] EXT_V    = X_W'(EXT_STEP);
  localparam logic [X_W-1:0] RET_V    = X_W'(RET_STEP);

  blitz_hook_state_t state, state_n;
  logic [Y_W-1:0]    y_n, hook_y_n;
  logic [X_W-1:0]    hook_x_n;
  logic              caught_n, done_n;
  logic [Y_W-1:0]    y_up_sat, y_dn_sat;
  logic [X_W-1:0]    x_ext_sat, x_ret_sat;
  logic              move_up_ok, move_dn_ok;

  // Saturating arithmetic written so no intermediate wraps.
  assign y_up_sat  = ((y <= Y_MIN_V) || ((y - Y_MIN_V) < MOVE_V)) ? Y_MIN_V : (y - MOVE_V);
  assign y_dn_sat  = ((y >= Y_MAX_V) || ((Y_MAX_V - y) < MOVE_V)) ? Y_MAX_V : (y + MOVE_V);
  assign x_ext_sat = ((hook_x >= XMAX_V) || ((XMAX_V - hook_x) < EXT_V)) ? XMAX_V : (hook_x + EXT_V);
  assign x_ret_sat = ((hook_x <= HOME_V) || ((hook_x - HOME_V) < RET_V)) ? HOME_V : (hook_x - RET_V);

  assign move_up_ok = go_up && !go_down && (y > Y_MIN_V);
  assign move_dn_ok = go_down && !go_up && (y < Y_MAX_V);

`ifdef BLITZ_HOOK_COOLDOWN_EN
  logic move_ret_cd, move_ret_cd_n;
  logic cd_load, cd_zero;

  hook_cooldown_timer #(
    .FRAMES (COOLDOWN_FRAMES)
  ) u_cooldown (
    .clk   (clk),
    .reset (reset),
    .load  (cd_load),
    .frame (frame),
    .zero  (cd_zero)
  );
`endif

  always_comb begin
    state_n  = state;
    y_n      = y;
    hook_x_n = hook_x;
    hook_y_n = hook_y;
    caught_n = hook_caught;
    done_n   = 1'b0;
`ifdef BLITZ_HOOK_COOLDOWN_EN
    move_ret_cd_n = move_ret_cd;
    cd_load       = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        hook_x_n = HOME_V;
        hook_y_n = '0;
`ifdef BLITZ_HOOK_COOLDOWN_EN
        move_ret_cd_n = 1'b0;
`endif
        if (grab) begin
          state_n  = ST_EXTEND;
          caught_n = 1'b0;
        end else if (move_up_ok) begin
          state_n = ST_MOVE_UP;
        end else if (move_dn_ok) begin
          state_n = ST_MOVE_DOWN;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (frame) begin
          y_n = (state == ST_MOVE_UP) ? y_up_sat : y_dn_sat;
`ifdef BLITZ_HOOK_COOLDOWN_EN
          state_n = move_ret_cd ? ST_COOLDOWN : ST_IDLE;
`else
          state_n = ST_IDLE;
`endif
        end
      end
      ST_EXTEND: begin
        if (frame) begin
          hook_x_n = x_ext_sat;
          hook_y_n = y + HY_OFS_V;
        end
        if (grab_success) begin
          caught_n = 1'b1;
        end
        // Exit test uses the current tip, every cycle, not only on frame.
        if (grab_success || (hook_x >= XMAX_V)) begin
          state_n = ST_RETRACT;
        end
      end
      ST_RETRACT: begin
        if (grab_success) begin
          caught_n = 1'b1;
        end
        if (hook_x <= HOME_V) begin
          hook_x_n = HOME_V;
          hook_y_n = '0;
          done_n   = 1'b1;
`ifdef BLITZ_HOOK_COOLDOWN_EN
          state_n  = ST_COOLDOWN;
          cd_load  = 1'b1;
`else
          state_n  = ST_IDLE;
`endif
        end else if (frame) begin
          hook_x_n = x_ret_sat;
        end
      end
`ifdef BLITZ_HOOK_COOLDOWN_EN
      ST_COOLDOWN: begin
        hook_x_n = HOME_V;
        hook_y_n = '0;
        // grab is deliberately not looked at while locked out.
        if (cd_zero) begin
          state_n = ST_IDLE;
        end else if (move_up_ok) begin
          state_n       = ST_MOVE_UP;
          move_ret_cd_n = 1'b1;
        end else if (move_dn_ok) begin
          state_n       = ST_MOVE_DOWN;
          move_ret_cd_n = 1'b1;
        end
      end
`endif
      default: begin
        state_n  = ST_IDLE;
        hook_x_n = HOME_V;
        hook_y_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      y           <= Y_RST_V;
      hook_x      <= HOME_V;
      hook_y      <= '0;
      hook_active <= 1'b0;
      hook_caught <= 1'b0;
      grab_done   <= 1'b0;
      busy        <= 1'b0;
`ifdef BLITZ_HOOK_COOLDOWN_EN
      move_ret_cd <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      y           <= y_n;
      hook_x      <= hook_x_n;
      hook_y      <= hook_y_n;
      hook_active <= (state_n == ST_EXTEND) || (state_n == ST_RETRACT);
      hook_caught <= caught_n;
      grab_done   <= done_n;
      busy        <= (state_n != ST_IDLE);
`ifdef BLITZ_HOOK_COOLDOWN_EN
      move_ret_cd <= move_ret_cd_n;
`endif
    end
  end

  assign dbg_state = state;

endmodule
